pipe_control: RTL and testbench
===============================

PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 The block SHALL have the parameter REG_AW, default 5, giving the register-address width.
REQ-002 The block SHALL have the parameter MUL_LAT, default 3, giving the MUL execute latency in cycles; the legal range is 1..8.
REQ-003 The block SHALL have the parameter ENABLE_MUL, default 1; when it is 0, MUL decodes as NOP.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  (rising edge); rst_i  in  1  (synchronous, active-high).
REQ-005 The block SHALL have the input port instr_i  in  32  instruction currently in IF/ID.
REQ-006 The block SHALL have the input port instr_valid_i  in  1  qualifies instr_i; 0 decodes as a bubble.
REQ-007 The block SHALL have the input port branch_taken_i  in  1  EX-stage BEQ compare result.
REQ-008 The block SHALL have the output port stall_o  out  1  hold PC and IF/ID this cycle.
REQ-009 The block SHALL have the output port flush_o  out  1  squash IF/ID this cycle.
REQ-010 The block SHALL have the output ports ex_ctrl_o / mem_ctrl_o / wb_ctrl_o  out  10  stage control word {alu_ctrl[3:0], alu_src, mem_rd, mem_wr, reg_wr, mem_to_reg, branch}.
REQ-011 The block SHALL have the output ports ex_rd_o / mem_rd_o / wb_rd_o  out  REG_AW  destination register of each stage.

Function
REQ-012 The decode SHALL be combinational: instr[6:0] is the opcode; funct = {instr[31:25], instr[14:12]}.
REQ-013 The decode SHALL recognise R-type OR/AND/ADD/SUB/MUL, ADDI, LW, SW and BEQ.
REQ-014 An unknown opcode, an unknown R-type funct, or instr_valid_i=0 SHALL yield an all-zero word (NOP), never a latch.
REQ-015 Every clock, the control word and rd SHALL advance ID->EX->MEM->WB, giving one cycle of latency per stage and a 3-cycle latency from ID to wb_ctrl_o.
REQ-016 Load-use: if EX holds LW, ex_rd_o!=0, and ex_rd_o equals rs1, or equals rs2 when ID is R-type/SW/BEQ, then stall_o=1 for exactly one cycle, EX receives NOP, and ID is re-decoded the next cycle.
REQ-017 A MUL entering EX SHALL start a counter at MUL_LAT-1.
REQ-018 While the MUL counter is non-zero, FSM state is MUL_BUSY: stall_o=1, and the EX, MEM and WB registers hold their values.
REQ-019 The MUL counter SHALL decrement each cycle, and the FSM SHALL return to IDLE at 0.
REQ-020 With MUL_LAT=1, a MUL SHALL never enter MUL_BUSY.
REQ-021 Branch: when ex_ctrl_o.branch=1 and branch_taken_i=1, flush_o=1 for that cycle and the ID word loaded into EX is forced to NOP.
REQ-022 Priority, highest first, SHALL be: rst_i > branch flush > MUL_BUSY hold > load-use stall.
REQ-023 A branch flush SHALL override a simultaneous load-use stall, so stall_o=0 in that cycle.
REQ-024 A taken BEQ SHALL never coexist with MUL_BUSY, because EX holds a single instruction; if forced, MUL_BUSY wins and flush_o=0.
REQ-025 rd=0 SHALL never trigger a load-use stall.
REQ-026 SW and BEQ SHALL carry reg_wr=0.

Reset
REQ-027 With rst_i=1 sampled on a clk_i edge, all stage words and rd registers SHALL become 0, the MUL counter SHALL become 0, and the FSM SHALL enter IDLE.
REQ-028 stall_o and flush_o SHALL read 0 while rst_i=1.
REQ-029 A reset asserted mid-MUL_BUSY SHALL abort the multiply, and the first cycle after reset SHALL decode normally.

Structure
REQ-030 The Opcode_*, Funct_* and Ctrl_* constants and the control-word field bit positions SHALL live in the shared opcodes package.
REQ-031 The combinational decode SHALL be one sub-module, ctrl_decode (instr, valid -> 10-bit word, rd, rs1, rs2, uses_rs2).
REQ-032 The hazard logic, the MUL counter/FSM and the stage registers SHALL reside in pipe_control.

Verification
REQ-033 Scenario ADD: ADD x3,x1,x2 (0x002081B3) -> the next cycle ex_ctrl_o.alu_ctrl=Ctrl_ADD, reg_wr=1, ex_rd_o=3; wb_rd_o=3 three cycles after ID.
REQ-034 Scenario load-use: LW x5,0(x1) then ADD x6,x5,x2 -> stall_o=1 for one cycle, ex_ctrl_o=0 that cycle, and the ADD reaches EX one cycle late.
REQ-035 Scenario MUL: MUL x7,x1,x2 with MUL_LAT=3 -> stall_o=1 for 2 cycles and ex_ctrl_o stable; with MUL_LAT=1 -> no stall.
REQ-036 Scenario branch: BEQ in EX with branch_taken_i=1 while ID holds a dependent load-use ADD -> flush_o=1, stall_o=0, and the next ex_ctrl_o=0.
REQ-037 Scenario reset mid-MUL: rst_i pulsed in the second MUL_BUSY cycle -> all outputs are 0 the next cycle, and a following ADDI decodes with no residual stall.
REQ-038 Scenario rd=0 and invalid input: LW x0 followed by a use of x0 -> no stall; unknown opcode 0x7F, or instr_valid_i=0 -> NOP propagates.

Source files
------------

// File: rtl/pipe_control_pkg.sv
// Shared opcode, funct and ALU-control constants, plus the bit layout of the
// 10-bit stage control word {alu_ctrl[3:0], alu_src, mem_rd, mem_wr, reg_wr,
// mem_to_reg, branch}.
package pipe_control_pkg;

  // Control-word layout
  localparam int CW_W          = 10;
  localparam int CW_BRANCH     = 0;
  localparam int CW_MEM_TO_REG = 1;
  localparam int CW_REG_WR     = 2;
  localparam int CW_MEM_WR     = 3;
  localparam int CW_MEM_RD     = 4;
  localparam int CW_ALU_SRC    = 5;
  localparam int CW_ALU_LSB    = 6;
  localparam int CW_ALU_MSB    = 9;

  localparam logic [CW_W-1:0] CTRL_NOP = '0;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] Opcode_RTYPE = 7'b0110011;
  localparam logic [6:0] Opcode_ADDI  = 7'b0010011;
  localparam logic [6:0] Opcode_LW    = 7'b0000011;
  localparam logic [6:0] Opcode_SW    = 7'b0100011;
  localparam logic [6:0] Opcode_BEQ   = 7'b1100011;

  // R-type funct = {funct7, funct3}
  localparam logic [9:0] Funct_ADD = 10'h000;
  localparam logic [9:0] Funct_SUB = 10'h100;
  localparam logic [9:0] Funct_OR  = 10'h006;
  localparam logic [9:0] Funct_AND = 10'h007;
  localparam logic [9:0] Funct_MUL = 10'h008;

  // ALU control encodings
  localparam logic [3:0] Ctrl_AND = 4'b0000;
  localparam logic [3:0] Ctrl_OR  = 4'b0001;
  localparam logic [3:0] Ctrl_ADD = 4'b0010;
  localparam logic [3:0] Ctrl_SUB = 4'b0110;
  localparam logic [3:0] Ctrl_MUL = 4'b1000;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } pipe_state_e;

  // Pack individual control fields into a control word.
  function automatic logic [CW_W-1:0] make_ctrl(
    input logic [3:0] alu,
    input logic       alu_src,
    input logic       mem_rd,
    input logic       mem_wr,
    input logic       reg_wr,
    input logic       mem_to_reg,
    input logic       branch
  );
    logic [CW_W-1:0] w;
    w                         = '0;
    w[CW_ALU_MSB:CW_ALU_LSB]  = alu;
    w[CW_ALU_SRC]             = alu_src;
    w[CW_MEM_RD]              = mem_rd;
    w[CW_MEM_WR]              = mem_wr;
    w[CW_REG_WR]              = reg_wr;
    w[CW_MEM_TO_REG]          = mem_to_reg;
    w[CW_BRANCH]              = branch;
    return w;
  endfunction

endpackage

// File: rtl/pipe_control_ctrl_decode.sv
// Combinational instruction decoder: turns the IF/ID instruction into a stage
// control word plus the register specifiers used by the hazard logic.
// Anything unrecognised, or an unqualified instruction, decodes as NOP.
module ctrl_decode
  import pipe_control_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int ENABLE_MUL = 1
) (
  input  logic [31:0]       instr_i,
  input  logic              valid_i,
  output logic [CW_W-1:0]   ctrl_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic              uses_rs2_o
);

  logic [6:0] opcode;
  logic [9:0] funct;
  logic       has_rd;

  assign opcode = instr_i[6:0];
  assign funct  = {instr_i[31:25], instr_i[14:12]};
  assign rs1_o  = REG_AW'(instr_i[19:15]);
  assign rs2_o  = REG_AW'(instr_i[24:20]);

  // Decode opcode/funct into a control word; defaults give a NOP.
  always_comb begin
    ctrl_o     = CTRL_NOP;
    has_rd     = 1'b0;
    uses_rs2_o = 1'b0;
    if (valid_i) begin
      case (opcode)
        Opcode_RTYPE: begin
          case (funct)
            Funct_ADD: ctrl_o = make_ctrl(Ctrl_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            Funct_SUB: ctrl_o = make_ctrl(Ctrl_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            Funct_OR:  ctrl_o = make_ctrl(Ctrl_OR,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            Funct_AND: ctrl_o = make_ctrl(Ctrl_AND, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            Funct_MUL: begin
              if (ENABLE_MUL != 0) begin
                ctrl_o = make_ctrl(Ctrl_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
              end
            end
            default:   ctrl_o = CTRL_NOP;
          endcase
          // An unknown funct must look like a full bubble, rd and rs2 included.
          has_rd     = (ctrl_o != CTRL_NOP);
          uses_rs2_o = (ctrl_o != CTRL_NOP);
        end
        Opcode_ADDI: begin
          ctrl_o = make_ctrl(Ctrl_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
          has_rd = 1'b1;
        end
        Opcode_LW: begin
          ctrl_o = make_ctrl(Ctrl_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
          has_rd = 1'b1;
        end
        Opcode_SW: begin
          ctrl_o     = make_ctrl(Ctrl_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
          uses_rs2_o = 1'b1;
        end
        Opcode_BEQ: begin
          ctrl_o     = make_ctrl(Ctrl_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          uses_rs2_o = 1'b1;
        end
        default: ctrl_o = CTRL_NOP;
      endcase
    end
  end

  // SW/BEQ and bubbles carry no destination, so they can never alias a load.
  assign rd_o = has_rd ? REG_AW'(instr_i[11:7]) : '0;

endmodule

// File: rtl/pipe_control.sv
// Pipeline control for a 5-stage in-order core: decodes ID, carries control
// words and destination registers down EX/MEM/WB, and resolves load-use
// stalls, multi-cycle MUL holds and taken-branch flushes.
module pipe_control
  import pipe_control_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MUL_LAT    = 3,
  parameter int ENABLE_MUL = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  input  logic              branch_taken_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [CW_W-1:0]   ex_ctrl_o,
  output logic [CW_W-1:0]   mem_ctrl_o,
  output logic [CW_W-1:0]   wb_ctrl_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic [REG_AW-1:0] wb_rd_o
);

  // MUL_LAT tops out at 8, so the counter never needs to hold more than 7.
  localparam int              CNT_W     = 4;
  localparam logic [CNT_W-1:0] MUL_START = CNT_W'(MUL_LAT - 1);

  logic [CW_W-1:0]   id_ctrl;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;

  pipe_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW_W-1:0]   ex_ctrl_q, ex_ctrl_d;
  logic [CW_W-1:0]   mem_ctrl_q, mem_ctrl_d;
  logic [CW_W-1:0]   wb_ctrl_q, wb_ctrl_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;

  logic              load_use;
  logic              branch_flush;
  logic              id_is_mul;
  logic              stall;
  logic              flush;

  ctrl_decode #(
    .REG_AW     (REG_AW),
    .ENABLE_MUL (ENABLE_MUL)
  ) u_decode (
    .instr_i    (instr_i),
    .valid_i    (instr_valid_i),
    .ctrl_o     (id_ctrl),
    .rd_o       (id_rd),
    .rs1_o      (id_rs1),
    .rs2_o      (id_rs2),
    .uses_rs2_o (id_uses_rs2)
  );

  // Hazard detection against the instruction currently in EX.
  always_comb begin
    load_use = 1'b0;
    if (ex_ctrl_q[CW_MEM_RD] && (ex_rd_q != '0) && (id_ctrl != CTRL_NOP)) begin
      load_use = (ex_rd_q == id_rs1) || (id_uses_rs2 && (ex_rd_q == id_rs2));
    end
    branch_flush = ex_ctrl_q[CW_BRANCH] && branch_taken_i;
    id_is_mul    = (id_ctrl[CW_ALU_MSB:CW_ALU_LSB] == Ctrl_MUL);
  end

  // Next-state, stage advance and stall/flush, in priority order:
  // reset, branch flush, MUL hold, load-use stall. A flush is only honoured
  // from IDLE so a forced branch during a multiply cannot break the hold.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_ctrl_d  = id_ctrl;
    ex_rd_d    = id_rd;
    mem_ctrl_d = ex_ctrl_q;
    mem_rd_d   = ex_rd_q;
    wb_ctrl_d  = mem_ctrl_q;
    wb_rd_d    = mem_rd_q;
    stall      = 1'b0;
    flush      = 1'b0;

    if (rst_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (branch_flush && (state_q == ST_IDLE)) begin
      flush     = 1'b1;
      ex_ctrl_d = CTRL_NOP;
      ex_rd_d   = '0;
    end else if (state_q == ST_MUL_BUSY) begin
      stall      = 1'b1;
      ex_ctrl_d  = ex_ctrl_q;
      ex_rd_d    = ex_rd_q;
      mem_ctrl_d = mem_ctrl_q;
      mem_rd_d   = mem_rd_q;
      wb_ctrl_d  = wb_ctrl_q;
      wb_rd_d    = wb_rd_q;
      cnt_d      = cnt_q - CNT_W'(1);
      state_d    = (cnt_d == '0) ? ST_IDLE : ST_MUL_BUSY;
    end else if (load_use) begin
      stall     = 1'b1;
      ex_ctrl_d = CTRL_NOP;
      ex_rd_d   = '0;
    end else if (id_is_mul && (MUL_START != '0)) begin
      cnt_d   = MUL_START;
      state_d = ST_MUL_BUSY;
    end
  end

  // Stage registers, MUL counter and FSM state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ex_ctrl_q  <= CTRL_NOP;
      mem_ctrl_q <= CTRL_NOP;
      wb_ctrl_q  <= CTRL_NOP;
      ex_rd_q    <= '0;
      mem_rd_q   <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      mem_rd_q   <= mem_rd_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign stall_o    = stall;
  assign flush_o    = flush;
  assign ex_ctrl_o  = ex_ctrl_q;
  assign mem_ctrl_o = mem_ctrl_q;
  assign wb_ctrl_o  = wb_ctrl_q;
  assign ex_rd_o    = ex_rd_q;
  assign mem_rd_o   = mem_rd_q;
  assign wb_rd_o    = wb_rd_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: one DUT at MUL_LAT=3 and one at MUL_LAT=1
// share the same stimulus.
module tb_pipe_control;

  // Hand-encoded instructions
  localparam logic [31:0] I_ADD    = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LW5    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD_X5 = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_SW_X5  = 32'h0050A023; // sw   x5,0(x1)
  localparam logic [31:0] I_ADDI_I = 32'h00508213; // addi x4,x1,5
  localparam logic [31:0] I_MUL    = 32'h022083B3; // mul  x7,x1,x2
  localparam logic [31:0] I_BEQ    = 32'h00208063; // beq  x1,x2,0
  localparam logic [31:0] I_ADDI   = 32'h00100213; // addi x4,x0,1
  localparam logic [31:0] I_LW0    = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD_X0 = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] I_BADOP  = 32'h0000007F;
  localparam logic [31:0] I_BADFN  = 32'h202081B3;

  // Expected control words {alu[3:0],src,mrd,mwr,rwr,m2r,br}
  localparam logic [9:0] W_ADD  = 10'h084;
  localparam logic [9:0] W_ADDI = 10'h0A4;
  localparam logic [9:0] W_LW   = 10'h0B6;
  localparam logic [9:0] W_MUL  = 10'h204;
  localparam logic [9:0] W_BEQ  = 10'h181;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        ivld = 1'b0;
  logic        taken = 1'b0;

  logic       stall, flush;
  logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       stall1, flush1;
  logic [9:0] ex_ctrl1, mem_ctrl1, wb_ctrl1;
  logic [4:0] ex_rd1, mem_rd1, wb_rd1;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] dec_ins [7] = '{32'h40208433, 32'h0020E4B3, 32'h0020F533,
                               32'h00100213, 32'h0020A023, 32'h00208063,
                               32'h0000A283};
  logic [9:0]  dec_cw  [7] = '{10'h184, 10'h044, 10'h004, 10'h0A4, 10'h0A8,
                               10'h181, 10'h0B6};
  logic [4:0]  dec_rd  [7] = '{5'd8, 5'd9, 5'd10, 5'd4, 5'd0, 5'd0, 5'd5};

  always #5 clk = ~clk;

  pipe_control #(.REG_AW(5), .MUL_LAT(3), .ENABLE_MUL(1)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(ivld),
    .branch_taken_i(taken), .stall_o(stall), .flush_o(flush),
    .ex_ctrl_o(ex_ctrl), .mem_ctrl_o(mem_ctrl), .wb_ctrl_o(wb_ctrl),
    .ex_rd_o(ex_rd), .mem_rd_o(mem_rd), .wb_rd_o(wb_rd)
  );

  pipe_control #(.REG_AW(5), .MUL_LAT(1), .ENABLE_MUL(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(ivld),
    .branch_taken_i(taken), .stall_o(stall1), .flush_o(flush1),
    .ex_ctrl_o(ex_ctrl1), .mem_ctrl_o(mem_ctrl1), .wb_ctrl_o(wb_ctrl1),
    .ex_rd_o(ex_rd1), .mem_rd_o(mem_rd1), .wb_rd_o(wb_rd1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    instr = ins;
    ivld  = v;
  endtask

  task automatic idle(input int n);
    drive(32'h0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; taken = 1'b1; drive(I_ADD, 1'b1);
    tick(); tick();
    n_total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b expected 0", stall); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL rst_flush: got %b expected 0", flush); else n_pass++;
    n_total++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 30'h0) $display("FAIL rst_ctrl: got %h %h %h expected 0", ex_ctrl, mem_ctrl, wb_ctrl); else n_pass++;
    n_total++; if ({ex_rd, mem_rd, wb_rd} !== 15'h0) $display("FAIL rst_rd: got %h %h %h expected 0", ex_rd, mem_rd, wb_rd); else n_pass++;
    rst = 1'b0; taken = 1'b0;
    idle(1);
  endtask

  task automatic test_add();
    idle(3);
    drive(I_ADD, 1'b1);
    tick();
    n_total++; if (ex_ctrl !== W_ADD) $display("FAIL add_ex_ctrl: got %h expected %h", ex_ctrl, W_ADD); else n_pass++;
    n_total++; if (ex_rd !== 5'd3) $display("FAIL add_ex_rd: got %0d expected 3", ex_rd); else n_pass++;
    drive(32'h0, 1'b0);
    tick();
    n_total++; if (mem_ctrl !== W_ADD) $display("FAIL add_mem_ctrl: got %h expected %h", mem_ctrl, W_ADD); else n_pass++;
    tick();
    n_total++; if (wb_ctrl !== W_ADD) $display("FAIL add_wb_ctrl: got %h expected %h", wb_ctrl, W_ADD); else n_pass++;
    n_total++; if (wb_rd !== 5'd3) $display("FAIL add_wb_rd: got %0d expected 3", wb_rd); else n_pass++;
  endtask

  task automatic test_decode();
    idle(3);
    for (int i = 0; i < 7; i++) begin
      drive(dec_ins[i], 1'b1);
      tick();
      n_total++; if (ex_ctrl !== dec_cw[i]) $display("FAIL decode_ctrl[%0d]: got %h expected %h", i, ex_ctrl, dec_cw[i]); else n_pass++;
      n_total++; if (ex_rd !== dec_rd[i]) $display("FAIL decode_rd[%0d]: got %0d expected %0d", i, ex_rd, dec_rd[i]); else n_pass++;
    end
    idle(1);
  endtask

  task automatic test_load_use();
    idle(3);
    drive(I_LW5, 1'b1);
    tick();
    drive(I_ADD_X5, 1'b1);
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b expected 1", stall); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL lu_flush: got %b expected 0", flush); else n_pass++;
    tick();
    n_total++; if (ex_ctrl !== 10'h0) $display("FAIL lu_bubble: got %h expected 000", ex_ctrl); else n_pass++;
    n_total++; if (mem_ctrl !== W_LW) $display("FAIL lu_mem_lw: got %h expected %h", mem_ctrl, W_LW); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL lu_one_cycle: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++; if (ex_ctrl !== W_ADD || ex_rd !== 5'd6) $display("FAIL lu_late_add: got %h/%0d expected %h/6", ex_ctrl, ex_rd, W_ADD); else n_pass++;
    // rs2 dependency through a store
    drive(I_LW5, 1'b1);
    tick();
    drive(I_SW_X5, 1'b1);
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL lu_rs2_stall: got %b expected 1", stall); else n_pass++;
    tick();
    // I-type immediate bits in the rs2 field must not cause a stall
    drive(I_LW5, 1'b1);
    tick();
    drive(I_ADDI_I, 1'b1);
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL lu_itype_nostall: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++; if (ex_ctrl !== W_ADDI) $display("FAIL lu_itype_ex: got %h expected %h", ex_ctrl, W_ADDI); else n_pass++;
  endtask

  task automatic test_mul();
    idle(3);
    drive(I_MUL, 1'b1);
    #1;
    n_total++; if (stall !== 1'b0 || stall1 !== 1'b0) $display("FAIL mul_pre_stall: got %b/%b expected 0/0", stall, stall1); else n_pass++;
    tick();
    drive(I_ADDI, 1'b1);
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL mul_busy1_stall: got %b expected 1", stall); else n_pass++;
    n_total++; if (ex_ctrl !== W_MUL || ex_rd !== 5'd7) $display("FAIL mul_ex: got %h/%0d expected %h/7", ex_ctrl, ex_rd, W_MUL); else n_pass++;
    n_total++; if (stall1 !== 1'b0) $display("FAIL mul_lat1_nostall: got %b expected 0", stall1); else n_pass++;
    n_total++; if (ex_ctrl1 !== W_MUL) $display("FAIL mul_lat1_ex: got %h expected %h", ex_ctrl1, W_MUL); else n_pass++;
    tick();
    n_total++; if (stall !== 1'b1) $display("FAIL mul_busy2_stall: got %b expected 1", stall); else n_pass++;
    n_total++; if (ex_ctrl !== W_MUL) $display("FAIL mul_hold_ex: got %h expected %h", ex_ctrl, W_MUL); else n_pass++;
    n_total++; if (mem_ctrl !== 10'h0) $display("FAIL mul_hold_mem: got %h expected 000", mem_ctrl); else n_pass++;
    n_total++; if (ex_ctrl1 !== W_ADDI || mem_ctrl1 !== W_MUL) $display("FAIL mul_lat1_adv: got %h/%h expected %h/%h", ex_ctrl1, mem_ctrl1, W_ADDI, W_MUL); else n_pass++;
    tick();
    n_total++; if (stall !== 1'b0) $display("FAIL mul_done_stall: got %b expected 0", stall); else n_pass++;
    n_total++; if (ex_ctrl !== W_MUL) $display("FAIL mul_last_ex: got %h expected %h", ex_ctrl, W_MUL); else n_pass++;
    tick();
    n_total++; if (ex_ctrl !== W_ADDI || mem_ctrl !== W_MUL) $display("FAIL mul_release: got %h/%h expected %h/%h", ex_ctrl, mem_ctrl, W_ADDI, W_MUL); else n_pass++;
  endtask

  task automatic test_branch();
    idle(3);
    drive(I_BEQ, 1'b1);
    tick();
    drive(I_ADD_X5, 1'b1);
    taken = 1'b1;
    #1;
    n_total++; if (flush !== 1'b1) $display("FAIL br_flush: got %b expected 1", flush); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL br_stall: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++; if (ex_ctrl !== 10'h0) $display("FAIL br_squash: got %h expected 000", ex_ctrl); else n_pass++;
    n_total++; if (mem_ctrl !== W_BEQ) $display("FAIL br_mem: got %h expected %h", mem_ctrl, W_BEQ); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL br_no_branch_in_ex: got %b expected 0", flush); else n_pass++;
    taken = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    idle(3);
    drive(I_MUL, 1'b1);
    tick();
    drive(I_ADDI, 1'b1);
    tick();
    n_total++; if (stall !== 1'b1) $display("FAIL rmul_busy: got %b expected 1", stall); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (stall !== 1'b0 || flush !== 1'b0) $display("FAIL rmul_in_rst: got %b/%b expected 0/0", stall, flush); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 30'h0 || {ex_rd, mem_rd, wb_rd} !== 15'h0) $display("FAIL rmul_cleared: got %h %h %h expected 0", ex_ctrl, mem_ctrl, wb_ctrl); else n_pass++;
    n_total++; if (stall !== 1'b0 || flush !== 1'b0) $display("FAIL rmul_after_rst: got %b/%b expected 0/0", stall, flush); else n_pass++;
    tick();
    n_total++; if (ex_ctrl !== W_ADDI || ex_rd !== 5'd4) $display("FAIL rmul_addi: got %h/%0d expected %h/4", ex_ctrl, ex_rd, W_ADDI); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL rmul_no_residual: got %b expected 0", stall); else n_pass++;
  endtask

  task automatic test_rd0_invalid();
    idle(3);
    drive(I_LW0, 1'b1);
    tick();
    n_total++; if (ex_ctrl !== W_LW || ex_rd !== 5'd0) $display("FAIL x0_lw: got %h/%0d expected %h/0", ex_ctrl, ex_rd, W_LW); else n_pass++;
    drive(I_ADD_X0, 1'b1);
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL x0_nostall: got %b expected 0", stall); else n_pass++;
    tick();
    n_total++; if (ex_ctrl !== W_ADD) $display("FAIL x0_add: got %h expected %h", ex_ctrl, W_ADD); else n_pass++;
    drive(I_BADOP, 1'b1);
    tick();
    n_total++; if (ex_ctrl !== 10'h0 || ex_rd !== 5'd0) $display("FAIL badop_nop: got %h/%0d expected 000/0", ex_ctrl, ex_rd); else n_pass++;
    drive(I_ADD, 1'b0);
    tick();
    n_total++; if (ex_ctrl !== 10'h0) $display("FAIL invalid_nop: got %h expected 000", ex_ctrl); else n_pass++;
    drive(I_BADFN, 1'b1);
    tick();
    n_total++; if (ex_ctrl !== 10'h0 || ex_rd !== 5'd0) $display("FAIL badfunct_nop: got %h/%0d expected 000/0", ex_ctrl, ex_rd); else n_pass++;
    n_total++; if (mem_ctrl !== 10'h0 || wb_ctrl !== 10'h0) $display("FAIL nop_propagate: got %h/%h expected 000/000", mem_ctrl, wb_ctrl); else n_pass++;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_load_use();
    test_mul();
    test_branch();
    test_reset_mid_mul();
    test_rd0_invalid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
